// File: rtl/branch_resolver_pkg.sv
// Shared opcode constants, BHT counter encodings and the saturating counter update.
package branch_resolver_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_B_TYPE = 7'b1100011;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } bht_cnt_e;

  function automatic logic [1:0] cnt_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CntSt) ? CntSt : cnt + 2'd1;
    end
    return (cnt == CntSnt) ? CntSnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolver_bht_table.sv
// 2-bit saturating counter array: one combinational read port, one synchronous update port.
module branch_resolver_bht_table
  import branch_resolver_pkg::*;
#(
  parameter int unsigned IdxW   = 6,
  parameter logic [1:0]  CntRst = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [IdxW-1:0] rd_idx_i,
  output logic [1:0]      rd_cnt_o,
  input  logic            upd_en_i,
  input  logic [IdxW-1:0] upd_idx_i,
  input  logic            upd_taken_i
);

  localparam int unsigned Entries = 1 << IdxW;

  logic [1:0] cnt_q [Entries];
  logic [1:0] cnt_d [Entries];

  // Read sees the registered array, so a same-cycle update is not visible until next cycle.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    cnt_d = cnt_q;
    if (upd_en_i) begin
      cnt_d[upd_idx_i] = cnt_update(cnt_q[upd_idx_i], upd_taken_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CntRst;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves execute-stage control flow against the fetch prediction and owns the BHT.
// Optional BRANCH_STATS_EN adds branch / misprediction counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned BHT_IDX_W = 6,
  parameter logic [1:0]  CNT_RST   = 2'b01
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] query_pc,
  output logic        query_taken,
  input  logic        res_valid,
  input  logic [6:0]  res_op,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  input  logic [31:0] res_pred_pc,
`ifdef BRANCH_STATS_EN
  output logic [31:0] stat_branch_cnt,
  output logic [31:0] stat_miss_cnt,
`endif
  output logic        flush_out,
  output logic [31:0] redirect_pc_out
);

  logic        flush_q, flush_d;
  logic [31:0] redirect_q, redirect_d;
  logic        accept, is_branch, is_jump, mispredict;
  logic [31:0] pc_plus4, actual_next;
  logic [1:0]  query_cnt;
  logic        unused_query;

  assign unused_query = ^{query_pc[31:BHT_IDX_W+2], query_pc[1:0], query_cnt[0]};

  // flush_q doubles as the wrong-path shadow: the resolve right after a flush is dropped.
  assign accept    = rdy_in & res_valid & ~flush_q;
  assign is_branch = (res_op == OP_B_TYPE);
  assign is_jump   = (res_op == OP_JAL) | (res_op == OP_JALR);
  assign pc_plus4  = res_pc + 32'd4;

  always_comb begin
    actual_next = pc_plus4;
    if (is_jump || (is_branch && res_taken)) begin
      actual_next = res_target;
    end
  end

  assign mispredict = (actual_next != res_pred_pc);

  always_comb begin
    flush_d    = flush_q;
    redirect_d = redirect_q;
    if (rdy_in) begin
      flush_d = accept & mispredict;
      if (accept) begin
        redirect_d = actual_next;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush_out       = flush_q;
  assign redirect_pc_out = redirect_q;

  branch_resolver_bht_table #(
    .IdxW   (BHT_IDX_W),
    .CntRst (CNT_RST)
  ) u_bht (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .rd_idx_i    (query_pc[BHT_IDX_W+1:2]),
    .rd_cnt_o    (query_cnt),
    .upd_en_i    (accept & is_branch),
    .upd_idx_i   (res_pc[BHT_IDX_W+1:2]),
    .upd_taken_i (res_taken)
  );

  assign query_taken = query_cnt[1];

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branch_q, stat_branch_d;
  logic [31:0] stat_miss_q, stat_miss_d;

  always_comb begin
    stat_branch_d = stat_branch_q;
    stat_miss_d   = stat_miss_q;
    if (accept && is_branch) begin
      stat_branch_d = stat_branch_q + 32'd1;
    end
    if (accept && mispredict) begin
      stat_miss_d = stat_miss_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_branch_q <= '0;
      stat_miss_q   <= '0;
    end else begin
      stat_branch_q <= stat_branch_d;
      stat_miss_q   <= stat_miss_d;
    end
  end

  assign stat_branch_cnt = stat_branch_q;
  assign stat_miss_cnt   = stat_miss_q;
`endif

endmodule
